// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS core types, fetch FSM encoding and opcode/funct constants
// used by fetch and decode.
package mips_pkg;
    typedef logic [31:0] pc_t;
    typedef logic [31:0] inst_t;
    typedef enum logic [1:0] {S_BOOT = 2'd0, S_FETCH = 2'd1, S_HALT = 2'd2} fetch_state_e;
    typedef struct packed {
        pc_t   pc;
        inst_t inst;
    } fetch_entry_t;
    localparam int PC_STEP = 4;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    function automatic pc_t pcNext(input pc_t pc);
        return pc + pc_t'(PC_STEP);
    endfunction
endpackage

// File: rtl/mips_fetch_unit_if.sv
// mips_fetch_unit_if: iCache read port plus the fetch-to-decode valid/ready channel.
// master = fetch unit, slave = iCache/decode side.
interface mips_fetch_unit_if;
    import mips_pkg::*;
    pc_t   iCacheReadAddr;
    inst_t iCacheReadData;
    logic  instValid;
    inst_t inst;
    pc_t   instPc;
    logic  instReady;
    modport master (output iCacheReadAddr, instValid, inst, instPc, input iCacheReadData, instReady);
    modport slave  (input iCacheReadAddr, instValid, inst, instPc, output iCacheReadData, instReady);
endinterface

// File: rtl/mips_fetch_unit_queue.sv
// fetch_queue: prefetch FIFO of {pc, inst}; flush wins over push/pop, pointers wrap modulo DEPTH.
module fetch_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           pushData,
    output fetch_entry_t           headData,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] rdPtr, wrPtr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wrPtr] <= pushData;
    end

    assign headData = mem[rdPtr];
endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: MIPS instruction fetch with credit-based prefetch queue and redirect flush.
// Optional FETCH_PERF_EN adds saturating fetch/stall performance counters.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter int  QUEUE_DEPTH = 4,
    parameter pc_t RESET_PC    = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    mips_fetch_unit_if.master        bus,
    input  logic                     haltReq,
    input  logic                     redirectValid,
    input  pc_t                      redirectPc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]              perfFetchCnt,
    output logic [31:0]              perfStallCnt
`endif
);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [1:0] ST_BOOT  = S_BOOT;
    localparam logic [1:0] ST_FETCH = S_FETCH;
    localparam logic [1:0] ST_HALT  = S_HALT;

    logic [1:0]    state;
    logic          inflight, issue, push, pop, creditFull;
    pc_t           fetchPc, inflightPc;
    logic [CW-1:0] count;
    fetch_entry_t  head;

    // Credit counts the in-flight word so a returning word always has a free slot.
    always_comb begin
        creditFull = count + CW'(inflight) >= CW'(QUEUE_DEPTH);
        issue      = state == ST_FETCH && !redirectValid && !creditFull;
        push       = inflight && !redirectValid;
        pop        = bus.instValid && bus.instReady && !redirectValid;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_BOOT;
            fetchPc    <= RESET_PC;
            inflight   <= 1'b0;
            inflightPc <= '0;
        end else begin
            state      <= state == ST_BOOT ? ST_FETCH : haltReq ? ST_HALT : ST_FETCH;
            fetchPc    <= redirectValid ? (redirectPc & ~pc_t'(3)) : issue ? pcNext(fetchPc) : fetchPc;
            inflight   <= issue;
            inflightPc <= issue ? fetchPc : inflightPc;
        end
    end

    fetch_queue #(.DEPTH(QUEUE_DEPTH)) uQueue (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .flush    (redirectValid),
        .pushData ({inflightPc, bus.iCacheReadData}),
        .headData (head),
        .count    (count)
    );

    assign bus.iCacheReadAddr = fetchPc;
    assign bus.instValid      = count != '0;
    assign bus.inst           = bus.instValid ? head.inst : '0;
    assign bus.instPc         = bus.instValid ? head.pc : '0;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perfFetchCnt <= '0;
            perfStallCnt <= '0;
        end else begin
            if (push && perfFetchCnt != '1) perfFetchCnt <= perfFetchCnt + 1'b1;
            if (state == ST_FETCH && !redirectValid && creditFull && perfStallCnt != '1)
                perfStallCnt <= perfStallCnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: scoreboard bench for mips_fetch_unit; define FETCH_PERF_EN to also
// check the performance counters.
module tb_mips_fetch_unit;
    logic        clk, rst, haltReq, redirectValid;
    logic [31:0] redirectPc;
    int          checks = 0, errors = 0, popCount = 0;
    logic [31:0] lastPopPc = '0;
    logic [63:0] sbQ [$];
`ifdef FETCH_PERF_EN
    logic [31:0] perfFetchCnt, perfStallCnt;
`endif

    mips_fetch_unit_if bus ();

    mips_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .haltReq       (haltReq),
        .redirectValid (redirectValid),
        .redirectPc    (redirectPc)
`ifdef FETCH_PERF_EN
        ,
        .perfFetchCnt  (perfFetchCnt),
        .perfStallCnt  (perfStallCnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word(input logic [31:0] p);
        return {p[15:0], ~p[15:0]} ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic sbLoad(input logic [31:0] start, input int n);
        sbQ.delete();
        for (int i = 0; i < n; i++) sbQ.push_back({start + 32'(4 * i), word(start + 32'(4 * i))});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // iCache: registered read, word valid the cycle after its address
    always @(posedge clk) bus.iCacheReadData <= word(bus.iCacheReadAddr);

    always @(negedge clk) begin
        logic [63:0] exp;
        if (rst && !redirectValid && bus.instValid && bus.instReady) begin
            exp = '1;
            if (sbQ.size() != 0) exp = sbQ.pop_front();
            check("popPc", bus.instPc, exp[63:32]);
            check("popInst", bus.inst, exp[31:0]);
            popCount++;
            lastPopPc = bus.instPc;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int p0, n;
        logic [31:0] a;
        rst = 1'b0;
        haltReq = 1'b0;
        redirectValid = 1'b0;
        redirectPc = '0;
        bus.instReady = 1'b1;
        #2;
        check("rstValid", 32'(bus.instValid), 0);
        check("rstInst", bus.inst, 0);
        check("rstInstPc", bus.instPc, 0);
        check("rstAddr", bus.iCacheReadAddr, 0);
        sbLoad(0, 40);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        step(1);
        check("bootValid1", 32'(bus.instValid), 0);
        step(1);
        check("bootValid2", 32'(bus.instValid), 0);
        check("bootAddr2", bus.iCacheReadAddr, 32'h4);
        step(1);
        check("firstValid", 32'(bus.instValid), 1);
        check("firstPc", bus.instPc, 0);
        check("firstInst", bus.inst, word(0));
        step(8);

        // fill with decode stalled from reset
        rst = 1'b0;
        bus.instReady = 1'b0;
        sbLoad(0, 40);
        #2 rst = 1'b1;
        step(12);
        check("fullValid", 32'(bus.instValid), 1);
        check("fullHeadPc", bus.instPc, 0);
        check("fullAddr", bus.iCacheReadAddr, 32'h10);
`ifdef FETCH_PERF_EN
        check("perfFetchFull", perfFetchCnt, 4);
        check("perfStallFull", perfStallCnt, 7);
`endif
        p0 = popCount;
        bus.instReady = 1'b1;
        step(8);
        check("drainNoGap", 32'(popCount - p0), 8);

        // redirect with queue loaded and a fetch in flight
        bus.instReady = 1'b0;
        step(2);
        sbLoad(32'h100, 40);
        redirectValid = 1'b1;
        redirectPc = 32'h103;
        step(1);
        redirectValid = 1'b0;
        check("redirValid0", 32'(bus.instValid), 0);
        check("redirAddr", bus.iCacheReadAddr, 32'h100);
        step(1);
        check("redirValid1", 32'(bus.instValid), 0);
        step(1);
        check("redirValid2", 32'(bus.instValid), 1);
        check("redirPc", bus.instPc, 32'h100);
        bus.instReady = 1'b1;
        step(5);

        // redirect coinciding with a pop
        sbLoad(32'h200, 40);
`ifdef FETCH_PERF_EN
        a = perfFetchCnt;
`endif
        redirectValid = 1'b1;
        redirectPc = 32'h200;
        step(1);
        redirectValid = 1'b0;
        check("popRedirValid", 32'(bus.instValid), 0);
`ifdef FETCH_PERF_EN
        check("perfDropped", perfFetchCnt, a);
`endif
        step(2);
        check("popRedirPc", bus.instPc, 32'h200);
        step(4);

        // PC wrap
        sbLoad(32'hFFFF_FFFC, 40);
        redirectValid = 1'b1;
        redirectPc = 32'hFFFF_FFFC;
        step(1);
        redirectValid = 1'b0;
        step(2);
        check("wrapPc0", bus.instPc, 32'hFFFF_FFFC);
        step(1);
        check("wrapPc1", bus.instPc, 32'h0);
        step(1);
        check("wrapPc2", bus.instPc, 32'h4);
        step(3);

        // halt mid-stream
        haltReq = 1'b1;
        step(1);
        a = bus.iCacheReadAddr;
        step(6);
        check("haltAddr", bus.iCacheReadAddr, a);
        check("haltDrained", 32'(bus.instValid), 0);
        check("haltLastPc", lastPopPc, a - 32'h4);
        haltReq = 1'b0;
        step(6);

        // redirect while halted
        haltReq = 1'b1;
        step(3);
        sbLoad(32'h300, 40);
        redirectValid = 1'b1;
        redirectPc = 32'h300;
        step(1);
        redirectValid = 1'b0;
        check("haltRedirAddr", bus.iCacheReadAddr, 32'h300);
        step(4);
        check("haltRedirHold", bus.iCacheReadAddr, 32'h300);
        check("haltRedirValid", 32'(bus.instValid), 0);
        p0 = popCount;
        haltReq = 1'b0;
        step(6);
        check("resumePops", 32'(popCount - p0), 3);

        // async reset pulse mid-fetch
        rst = 1'b0;
        sbLoad(0, 40);
        #1;
        check("asyncValid", 32'(bus.instValid), 0);
        check("asyncAddr", bus.iCacheReadAddr, 0);
`ifdef FETCH_PERF_EN
        check("asyncPerf", perfFetchCnt, 0);
`endif
        #1 rst = 1'b1;
        n = 0;
        while (!bus.instValid && n < 10) begin
            step(1);
            n++;
        end
        check("asyncRecover", 32'(bus.instValid), 1);
        check("asyncPc", bus.instPc, 0);
        step(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
